// File: rtl/decode_stage_pkg.sv
// Shared Y86-64 encodings for the decode stage: instruction codes and special register IDs.
package decode_stage_pkg;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   localparam logic [3:0] RSP     = 4'h4;
   localparam logic [3:0] RNONE   = 4'hF;

   localparam int NUM_REGS = 15;

endpackage

// File: rtl/decode_stage_regfile.sv
// 15 x 64-bit register file: two combinational read ports, two write ports, async clear.
module regfile
   import decode_stage_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [3:0]  i_srcA,
   input  logic [3:0]  i_srcB,
   output logic [63:0] o_valA,
   output logic [63:0] o_valB,
   input  logic [3:0]  i_dstE,
   input  logic [63:0] i_valE,
   input  logic [3:0]  i_dstM,
   input  logic [63:0] i_valM
);

   logic [63:0] r_regs [NUM_REGS];

   // The M port is written last so it wins when both ports target the same register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         if (i_dstE != RNONE) begin
            r_regs[i_dstE] <= i_valE;
         end
         if (i_dstM != RNONE) begin
            r_regs[i_dstM] <= i_valM;
         end
      end
   end

   assign o_valA = (i_srcA == RNONE) ? '0 : r_regs[i_srcA];
   assign o_valB = (i_srcB == RNONE) ? '0 : r_regs[i_srcB];

endmodule

// File: rtl/decode_stage.sv
// Pipeline decode stage: register ID selection, operand forwarding and the register file.
module decode_stage
   import decode_stage_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [2:0]  D_stat_i,
   input  logic [63:0] D_pc_i,
   input  logic [3:0]  D_icode_i,
   input  logic [3:0]  D_ifun_i,
   input  logic [3:0]  D_rA_i,
   input  logic [3:0]  D_rB_i,
   input  logic [63:0] D_valC_i,
   input  logic [63:0] D_valP_i,
   input  logic [3:0]  e_dstE_i,
   input  logic [63:0] e_valE_i,
   input  logic [3:0]  M_dstM_i,
   input  logic [63:0] m_valM_i,
   input  logic [3:0]  M_dstE_i,
   input  logic [63:0] M_valE_i,
   input  logic [3:0]  W_dstM_i,
   input  logic [63:0] W_valM_i,
   input  logic [3:0]  W_dstE_i,
   input  logic [63:0] W_valE_i,
   output logic [2:0]  d_stat_o,
   output logic [63:0] d_pc_o,
   output logic [3:0]  d_icode_o,
   output logic [3:0]  d_ifun_o,
   output logic [63:0] d_valC_o,
   output logic [63:0] d_valA_o,
   output logic [63:0] d_valB_o,
   output logic [3:0]  d_srcA_o,
   output logic [3:0]  d_srcB_o,
   output logic [3:0]  d_dstE_o,
   output logic [3:0]  d_dstM_o
);

   logic [3:0]  w_srcA;
   logic [3:0]  w_srcB;
   logic [3:0]  w_dstE;
   logic [3:0]  w_dstM;
   logic [63:0] w_rf_valA;
   logic [63:0] w_rf_valB;
   logic [63:0] w_valA;
   logic [63:0] w_valB;

   regfile u_regfile (
      .i_clk   (clk_i),
      .i_rst_n (rst_n_i),
      .i_srcA  (w_srcA),
      .i_srcB  (w_srcB),
      .o_valA  (w_rf_valA),
      .o_valB  (w_rf_valB),
      .i_dstE  (W_dstE_i),
      .i_valE  (W_valE_i),
      .i_dstM  (W_dstM_i),
      .i_valM  (W_valM_i)
   );

   // Illegal icodes fall through to the defaults, giving RNONE everywhere.
   always_comb begin
      w_srcA = RNONE;
      w_srcB = RNONE;
      w_dstE = RNONE;
      w_dstM = RNONE;
      case (D_icode_i)
         IRRMOVQ: begin
            w_srcA = D_rA_i;
            w_dstE = D_rB_i;
         end
         IIRMOVQ: w_dstE = D_rB_i;
         IRMMOVQ: begin
            w_srcA = D_rA_i;
            w_srcB = D_rB_i;
         end
         IMRMOVQ: begin
            w_srcB = D_rB_i;
            w_dstM = D_rA_i;
         end
         IOPQ: begin
            w_srcA = D_rA_i;
            w_srcB = D_rB_i;
            w_dstE = D_rB_i;
         end
         ICALL: begin
            w_srcB = RSP;
            w_dstE = RSP;
         end
         IRET: begin
            w_srcA = RSP;
            w_srcB = RSP;
            w_dstE = RSP;
         end
         IPUSHQ: begin
            w_srcA = D_rA_i;
            w_srcB = RSP;
            w_dstE = RSP;
         end
         IPOPQ: begin
            w_srcA = RSP;
            w_srcB = RSP;
            w_dstE = RSP;
            w_dstM = D_rA_i;
         end
         default: ;
      endcase
   end

   // Youngest producer wins; RNONE sources never match, even against an RNONE destination.
   always_comb begin
      w_valA = w_rf_valA;
      if (D_icode_i == ICALL || D_icode_i == IJXX) w_valA = D_valP_i;
      else if (w_srcA == RNONE)                    w_valA = '0;
      else if (w_srcA == e_dstE_i)                 w_valA = e_valE_i;
      else if (w_srcA == M_dstM_i)                 w_valA = m_valM_i;
      else if (w_srcA == M_dstE_i)                 w_valA = M_valE_i;
      else if (w_srcA == W_dstM_i)                 w_valA = W_valM_i;
      else if (w_srcA == W_dstE_i)                 w_valA = W_valE_i;
   end

   always_comb begin
      w_valB = w_rf_valB;
      if (w_srcB == RNONE)         w_valB = '0;
      else if (w_srcB == e_dstE_i) w_valB = e_valE_i;
      else if (w_srcB == M_dstM_i) w_valB = m_valM_i;
      else if (w_srcB == M_dstE_i) w_valB = M_valE_i;
      else if (w_srcB == W_dstM_i) w_valB = W_valM_i;
      else if (w_srcB == W_dstE_i) w_valB = W_valE_i;
   end

   assign d_stat_o  = D_stat_i;
   assign d_pc_o    = D_pc_i;
   assign d_icode_o = D_icode_i;
   assign d_ifun_o  = D_ifun_i;
   assign d_valC_o  = D_valC_i;
   assign d_valA_o  = w_valA;
   assign d_valB_o  = w_valB;
   assign d_srcA_o  = w_srcA;
   assign d_srcB_o  = w_srcB;
   assign d_dstE_o  = w_dstE;
   assign d_dstM_o  = w_dstM;

endmodule
